// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory access scheduler.
// Owner codes follow accmodule: 0 = nobody, k = requester k-1.
package mem_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_GRANT   = 3'b010,
    ST_PREEMPT = 3'b100
  } state_t;

  localparam logic [2:0] IDLE_OWNER      = 3'd0;
  localparam logic [2:0] HI_OWNER        = 3'd1;
  localparam int         DEF_QUOTA       = 2;
  localparam int         DEF_PREEMPT_MAX = 2;
  localparam int         CNT_W           = 8;

  // Context of a low-priority access interrupted by requester 0.
  typedef struct packed {
    logic [2:0]       owner;
    logic [CNT_W-1:0] quota;
  } ctx_t;

  function automatic logic [3:0] owner_oh(input logic [2:0] o);
    case (o)
      3'd1:    owner_oh = 4'b0001;
      3'd2:    owner_oh = 4'b0010;
      3'd3:    owner_oh = 4'b0100;
      3'd4:    owner_oh = 4'b1000;
      default: owner_oh = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_scheduler_rr_arbiter3.sv
// Round-robin pick among requesters 1..3; ptr names the requester (1..3)
// that has first priority, i.e. the one after the last low grant.
module rr_arbiter3 (
  input  logic [2:0] mask,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    case (ptr)
      2'd2: begin
        if      (mask[1]) gnt = 3'b010;
        else if (mask[2]) gnt = 3'b100;
        else if (mask[0]) gnt = 3'b001;
      end
      2'd3: begin
        if      (mask[2]) gnt = 3'b100;
        else if (mask[0]) gnt = 3'b001;
        else if (mask[1]) gnt = 3'b010;
      end
      default: begin
        if      (mask[0]) gnt = 3'b001;
        else if (mask[1]) gnt = 3'b010;
        else if (mask[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_scheduler.sv
// Single-port memory access scheduler: requester 0 is high priority and may
// preempt a quota-limited low-priority owner (1..3), which later resumes.
module mem_access_scheduler
  import mem_sched_pkg::*;
#(
  parameter int QUOTA       = DEF_QUOTA,
  parameter int PREEMPT_MAX = DEF_PREEMPT_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [2:0] accmodule,
  output logic [2:0] mstate,
  output logic [3:0] pending,
  output logic [7:0] nb_interrupts
);

  state_t           st, st_nxt;
  logic [2:0]       owner, owner_nxt;
  logic [CNT_W-1:0] q_cnt, q_nxt;
  logic [CNT_W-1:0] p_cnt, p_nxt;
  ctx_t             sv, sv_nxt;
  logic [1:0]       rr_ptr, ptr_nxt;
  logic [7:0]       nb_nxt;
  logic [3:0]       pend_nxt, gmask;
  logic [3:0]       cand;
  logic [2:0]       rr_gnt, arb_owner;
  logic             do_arb, done_own, cancel;

  assign cand     = req | pending;
  assign done_own = |(done & owner_oh(owner));
  assign cancel   = |(done & owner_oh(sv.owner));

  rr_arbiter3 u_rr (
    .mask (cand[3:1]),
    .ptr  (rr_ptr),
    .gnt  (rr_gnt)
  );

  always_comb begin
    arb_owner = IDLE_OWNER;
    if      (cand[0])   arb_owner = HI_OWNER;
    else if (rr_gnt[0]) arb_owner = 3'd2;
    else if (rr_gnt[1]) arb_owner = 3'd3;
    else if (rr_gnt[2]) arb_owner = 3'd4;
  end

  always_comb begin
    st_nxt    = st;
    owner_nxt = owner;
    q_nxt     = q_cnt;
    p_nxt     = p_cnt;
    sv_nxt    = sv;
    ptr_nxt   = rr_ptr;
    nb_nxt    = nb_interrupts;
    gmask     = '0;
    do_arb    = 1'b0;

    case (st)
      ST_IDLE: do_arb = 1'b1;
      ST_GRANT: begin
        if (owner == HI_OWNER) begin
          if (done[0]) do_arb = 1'b1;
        end else if (done_own || q_cnt == CNT_W'(1)) begin
          // Release or last quota cycle: this ends the access, so a
          // coincident req[0] is served by normal arbitration, not a preempt.
          do_arb = 1'b1;
        end else if (cand[0]) begin
          st_nxt    = ST_PREEMPT;
          owner_nxt = HI_OWNER;
          sv_nxt    = '{owner: owner, quota: q_cnt - CNT_W'(1)};
          p_nxt     = CNT_W'(PREEMPT_MAX);
          gmask     = 4'b0001;
          if (nb_interrupts != 8'hFF) nb_nxt = nb_interrupts + 8'd1;
        end else begin
          q_nxt = q_cnt - CNT_W'(1);
        end
      end
      ST_PREEMPT: begin
        if (done[0] || p_cnt == CNT_W'(1)) begin
          p_nxt  = '0;
          sv_nxt = '0;
          if (sv.owner != IDLE_OWNER && !cancel) begin
            st_nxt    = ST_GRANT;
            owner_nxt = sv.owner;
            q_nxt     = sv.quota;
          end else begin
            do_arb = 1'b1;
          end
        end else begin
          p_nxt = p_cnt - CNT_W'(1);
          if (cancel) sv_nxt.owner = IDLE_OWNER;
        end
      end
      default: begin
        st_nxt    = ST_IDLE;
        owner_nxt = IDLE_OWNER;
      end
    endcase

    if (do_arb) begin
      owner_nxt = arb_owner;
      gmask     = owner_oh(arb_owner);
      q_nxt     = '0;
      if (arb_owner == IDLE_OWNER) begin
        st_nxt = ST_IDLE;
      end else begin
        st_nxt = ST_GRANT;
        if (arb_owner != HI_OWNER) begin
          q_nxt   = CNT_W'(QUOTA);
          ptr_nxt = (arb_owner == 3'd4) ? 2'd1 : arb_owner[1:0];
        end
      end
    end

    pend_nxt = (pending | req) & ~gmask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= ST_IDLE;
      owner         <= IDLE_OWNER;
      q_cnt         <= '0;
      p_cnt         <= '0;
      sv            <= '0;
      rr_ptr        <= 2'd1;
      nb_interrupts <= '0;
      pending       <= '0;
    end else begin
      st            <= st_nxt;
      owner         <= owner_nxt;
      q_cnt         <= q_nxt;
      p_cnt         <= p_nxt;
      sv            <= sv_nxt;
      rr_ptr        <= ptr_nxt;
      nb_interrupts <= nb_nxt;
      pending       <= pend_nxt;
    end
  end

  assign accmodule = owner;
  assign mstate    = st;

endmodule
